// File: rtl/cordic_sincos.sv
// Fully pipelined rotation-mode CORDIC: 8-bit Q2.6 angle in, Q1.7 sine/cosine out.
// Angles beyond +/-pi/2 are folded by pi and the result is negated at the output.
module cordic_sincos #(
   parameter int ITERS = 12,
   parameter int IW    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic signed [7:0] in,
   output logic signed [7:0] sine,
   output logic signed [7:0] cosine
);

   localparam int XW = IW + 2;
   localparam logic signed [IW-1:0] HALF_PI  = IW'(12868);
   localparam logic signed [IW-1:0] PI       = IW'(25736);
   localparam logic signed [XW-1:0] K_GAIN   = XW'(9949);
   localparam logic signed [XW:0]   RND_HALF = (XW+1)'(64);
   localparam logic signed [XW:0]   SAT_HI   = (XW+1)'(127);
   localparam logic signed [XW:0]   SAT_LO   = -(XW+1)'(128);

   function automatic logic signed [IW-1:0] atan_c(input int idx);
      case (idx)
         0:       atan_c = IW'(6434);
         1:       atan_c = IW'(3798);
         2:       atan_c = IW'(2007);
         3:       atan_c = IW'(1019);
         4:       atan_c = IW'(511);
         5:       atan_c = IW'(256);
         6:       atan_c = IW'(128);
         7:       atan_c = IW'(64);
         8:       atan_c = IW'(32);
         9:       atan_c = IW'(16);
         10:      atan_c = IW'(8);
         11:      atan_c = IW'(4);
         12:      atan_c = IW'(2);
         13:      atan_c = IW'(1);
         default: atan_c = '0;
      endcase
   endfunction

   // Q2.14 -> Q1.7 round-to-nearest, clamped to the 8-bit signed range.
   function automatic logic signed [7:0] rnd_sat(input logic signed [XW-1:0] v);
      logic signed [XW:0] t;
      t = (XW+1)'(v) + RND_HALF;
      t = t >>> 7;
      if (t > SAT_HI)
         return 8'sh7F;
      else if (t < SAT_LO)
         return 8'sh80;
      else
         return t[7:0];
   endfunction

   logic signed [XW-1:0] r_x_p    [0:ITERS];
   logic signed [XW-1:0] r_y_p    [0:ITERS];
   logic signed [IW-1:0] r_z_p    [0:ITERS-1];
   logic                 r_fold_p [0:ITERS];
   logic signed [7:0]    r_sine;
   logic signed [7:0]    r_cosine;

   logic signed [IW-1:0] w_theta;
   logic signed [IW-1:0] w_z0;
   logic                 w_fold0;

   // Input stage: Q2.6 -> Q3.13, fold into [-pi/2, pi/2]
   assign w_theta = IW'(in) <<< 7;

   always_comb begin
      w_z0    = w_theta;
      w_fold0 = 1'b0;
      if (w_theta > HALF_PI) begin
         w_z0    = w_theta - PI;
         w_fold0 = 1'b1;
      end else if (w_theta < -HALF_PI) begin
         w_z0    = w_theta + PI;
         w_fold0 = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_x_p[0]    <= '0;
         r_y_p[0]    <= '0;
         r_z_p[0]    <= '0;
         r_fold_p[0] <= 1'b0;
      end else begin
         r_x_p[0]    <= K_GAIN;
         r_y_p[0]    <= '0;
         r_z_p[0]    <= w_z0;
         r_fold_p[0] <= w_fold0;
      end
   end

   // Rotation stages: drive z toward zero, one micro-rotation per stage
   for (genvar i = 0; i < ITERS; i++) begin : g_rot
      logic signed [XW-1:0] w_xs;
      logic signed [XW-1:0] w_ys;
      logic                 w_neg;

      assign w_xs  = r_x_p[i] >>> i;
      assign w_ys  = r_y_p[i] >>> i;
      assign w_neg = r_z_p[i][IW-1];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_x_p[i+1]    <= '0;
            r_y_p[i+1]    <= '0;
            r_fold_p[i+1] <= 1'b0;
         end else begin
            r_x_p[i+1]    <= w_neg ? r_x_p[i] + w_ys : r_x_p[i] - w_ys;
            r_y_p[i+1]    <= w_neg ? r_y_p[i] - w_xs : r_y_p[i] + w_xs;
            r_fold_p[i+1] <= r_fold_p[i];
         end
      end

      // The last stage's residual angle is never consumed.
      if (i < ITERS - 1) begin : g_z
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               r_z_p[i+1] <= '0;
            else
               r_z_p[i+1] <= w_neg ? r_z_p[i] + atan_c(i) : r_z_p[i] - atan_c(i);
         end
      end
   end

   // Output stage: undo the fold, round and saturate
   logic signed [XW-1:0] w_xo;
   logic signed [XW-1:0] w_yo;

   assign w_xo = r_fold_p[ITERS] ? -r_x_p[ITERS] : r_x_p[ITERS];
   assign w_yo = r_fold_p[ITERS] ? -r_y_p[ITERS] : r_y_p[ITERS];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sine   <= '0;
         r_cosine <= '0;
      end else begin
         r_sine   <= rnd_sat(w_yo);
         r_cosine <= rnd_sat(w_xo);
      end
   end

   assign sine   = r_sine;
   assign cosine = r_cosine;

endmodule

// File: tb/tb_cordic_sincos.sv
// Directed-vector bench for cordic_sincos: reset behaviour, latency, accuracy, fold
// region, back-to-back streaming and asynchronous mid-stream reset.
module tb_cordic_sincos;

   localparam int LAT = 14;
   localparam int NV  = 11;

   logic              clk    = 1'b0;
   logic              rst    = 1'b0;
   logic signed [7:0] in_ang = '0;
   logic signed [7:0] sine;
   logic signed [7:0] cosine;

   int n_chk = 0;
   int n_err = 0;

   // Angle (Q2.6) and hand-computed round(sin*128)/round(cos*128), saturated to [-128,127].
   int vin  [NV] = '{0,   14,  50, -50, 99,   -99,  127, -128, 101,  -101, 100};
   int esin [NV] = '{0,   28,  90, -90, 127,  -128, 117, -116, 127,  -128, 127};
   int ecos [NV] = '{127, 125, 91, 91,  3,    3,    -51, -53,  -1,   -1,   1};
   int etol [NV] = '{1,   2,   2,  2,   2,    2,    2,   2,    2,    2,    2};

   cordic_sincos dut (
      .clk    (clk),
      .rst    (rst),
      .in     (in_ang),
      .sine   (sine),
      .cosine (cosine)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp, input int tol);
      int diff;
      n_chk++;
      diff = got - exp;
      if (diff < 0) diff = -diff;
      if (diff > tol) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (+/-%0d)", tag, got, exp, tol);
      end
   endtask

   // Drives n vectors back to back, one per cycle, and checks each result exactly
   // LAT cycles later. With fresh set, reset is released on the first drive.
   task automatic run_stream(input int n, input int off, input bit fresh);
      int idx;
      for (int c = 0; c < n + LAT; c++) begin
         @(negedge clk);
         if (fresh && c == LAT - 1) begin
            chk("prevalid_sine", int'(sine), 0, 0);
            chk("prevalid_cosine", int'(cosine), 0, 0);
         end
         if (c >= LAT) begin
            idx = (c - LAT + off) % NV;
            chk($sformatf("sine[in=%0d]", vin[idx]), int'(sine), esin[idx], etol[idx]);
            chk($sformatf("cosine[in=%0d]", vin[idx]), int'(cosine), ecos[idx], etol[idx]);
         end
         if (fresh && c == 0) rst = 1'b1;
         if (c < n) in_ang = 8'(vin[(c + off) % NV]);
         else       in_ang = '0;
      end
   endtask

   initial begin
      // reset held with random angles on the input
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c >= 1) begin
            chk("rst_hold_sine", int'(sine), 0, 0);
            chk("rst_hold_cosine", int'(cosine), 0, 0);
         end
         in_ang = 8'($urandom);
      end

      // every directed vector, streamed back to back from a fresh pipeline
      run_stream(NV, 0, 1'b1);

      // longer stream with a different phase through the table
      run_stream(30, 3, 1'b0);

      // mid-stream asynchronous reset
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         in_ang = 8'(vin[c % NV]);
      end
      @(negedge clk);
      chk("pre_rst_cosine", int'(cosine), ecos[6], etol[6]);
      chk("pre_rst_sine", int'(sine), esin[6], etol[6]);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_sine", int'(sine), 0, 0);
      chk("async_rst_cosine", int'(cosine), 0, 0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         in_ang = 8'($urandom);
      end

      // in-flight angles must be gone after release
      run_stream(NV, 5, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
